// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch stage bus: execute redirect, instruction memory port and decode-side handshake.
interface fetch_queue_if #(
   parameter int unsigned WIDTH = 32
);
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rdata;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_instr;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_pc_plus4;

   modport master (
      input  redirect, redirect_pc, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
   );

   modport slave (
      output redirect, redirect_pc, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched entries with flush; head is read straight from storage.
module fetch_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_pkg::fetch_entry_t,
   localparam int unsigned PW     = $clog2(DEPTH),
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output entry_t        head
);

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          pop_ok;

   assign pop_ok = pop && (count != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   // Flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         assert (!(push && count == CW'(DEPTH)));
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Buffered fetch stage: owns the PC, issues sequential fetches and queues returns for decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } entry_t;

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] inflight_pc_q;
   logic             inflight_q;
   logic [CW-1:0]    count;
   logic [CW:0]      occupancy;
   logic             issue;
   logic             push;
   logic             pop;
   entry_t           push_data;
   entry_t           head;

   // Reserve a slot for the in-flight word so a return never finds the FIFO full.
   assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
   assign issue     = !bus.redirect && (occupancy < (CW+1)'(DEPTH));
   assign push      = inflight_q && !bus.redirect;
   assign pop       = bus.out_valid && bus.out_ready;
   assign push_data = '{pc: inflight_pc_q, instr: bus.imem_rdata};

   assign bus.imem_req     = rst && issue;
   assign bus.imem_addr    = pc_q;
   assign bus.out_valid    = (count != '0);
   assign bus.out_instr    = head.instr;
   assign bus.out_pc       = head.pc;
   assign bus.out_pc_plus4 = head.pc + WIDTH'(INSTR_BYTES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
      end else if (bus.redirect) begin
         pc_q       <= {bus.redirect_pc[WIDTH-1:2], 2'b00};
         inflight_q <= 1'b0;
      end else if (issue) begin
         pc_q          <= pc_q + WIDTH'(INSTR_BYTES);
         inflight_q    <= 1'b1;
         inflight_pc_q <= pc_q;
      end else begin
         inflight_q <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (bus.redirect),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a 1-cycle instruction memory model.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   fetch_queue_if #(.WIDTH(WIDTH)) bus ();

   fetch_queue #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Synchronous-read memory: data for the address presented this cycle appears next cycle.
   always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

   initial begin
      #100000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Hold reset two cycles, then release; caller is then in cycle 0.
   task automatic start(input logic ready);
      rst             = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = ready;
      cyc();
      cyc();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst             = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = 1'b0;
      cyc();
      cyc();
      #1;
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
      vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] ep;
      start(1'b1);
      for (int c = 0; c < 8; c++) begin
         #1;
         vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL stream_req c%0d got %b exp 1", c, bus.imem_req); end
         vectors++; if (bus.imem_addr !== 32'(4 * c)) begin miscompares++; $display("FAIL stream_addr c%0d got %h exp %h", c, bus.imem_addr, 32'(4 * c)); end
         if (c < 2) begin
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_valid c%0d got %b exp 0", c, bus.out_valid); end
         end else begin
            ep = 32'(4 * (c - 2));
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid c%0d got %b exp 1", c, bus.out_valid); end
            vectors++; if (bus.out_pc !== ep) begin miscompares++; $display("FAIL stream_pc c%0d got %h exp %h", c, bus.out_pc, ep); end
            vectors++; if (bus.out_instr !== mem_word(ep)) begin miscompares++; $display("FAIL stream_instr c%0d got %h exp %h", c, bus.out_instr, mem_word(ep)); end
            vectors++; if (bus.out_pc_plus4 !== ep + 32'd4) begin miscompares++; $display("FAIL stream_plus4 c%0d got %h exp %h", c, bus.out_pc_plus4, ep + 32'd4); end
         end
         cyc();
      end
   endtask

   task automatic test_stall();
      logic        er;
      logic [31:0] ea;
      logic [31:0] ep;
      start(1'b0);
      for (int c = 0; c < 13; c++) begin
         if (c == 7) bus.out_ready = 1'b1;
         #1;
         er = (c < 4) || (c >= 8);
         ea = (c < 4) ? 32'(4 * c) : 32'h10 + 32'(4 * (c - 8));
         vectors++; if (bus.imem_req !== er) begin miscompares++; $display("FAIL stall_req c%0d got %b exp %b", c, bus.imem_req, er); end
         if (er) begin
            vectors++; if (bus.imem_addr !== ea) begin miscompares++; $display("FAIL stall_addr c%0d got %h exp %h", c, bus.imem_addr, ea); end
         end
         if (c >= 2) begin
            ep = (c <= 7) ? 32'h0 : 32'(4 * (c - 7));
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid c%0d got %b exp 1", c, bus.out_valid); end
            vectors++; if (bus.out_pc !== ep) begin miscompares++; $display("FAIL stall_pc c%0d got %h exp %h", c, bus.out_pc, ep); end
         end
         cyc();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] ep;
      start(1'b0);
      repeat (4) cyc();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h100;
      bus.out_ready   = 1'b1;
      #1;
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req got %b exp 0", bus.imem_req); end
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL redir_prefill got %b exp 1", bus.out_valid); end
      cyc();
      bus.redirect = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_bubble k%0d got %b exp 0", k, bus.out_valid); end
         vectors++; if (bus.imem_addr !== 32'h100 + 32'(4 * k)) begin miscompares++; $display("FAIL redir_addr k%0d got %h exp %h", k, bus.imem_addr, 32'h100 + 32'(4 * k)); end
         cyc();
      end
      for (int k = 0; k < 3; k++) begin
         ep = 32'h100 + 32'(4 * k);
         #1;
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL redir_valid k%0d got %b exp 1", k, bus.out_valid); end
         vectors++; if (bus.out_pc !== ep) begin miscompares++; $display("FAIL redir_pc k%0d got %h exp %h", k, bus.out_pc, ep); end
         vectors++; if (bus.out_instr !== mem_word(ep)) begin miscompares++; $display("FAIL redir_instr k%0d got %h exp %h", k, bus.out_instr, mem_word(ep)); end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h103;
      cyc();
      bus.redirect = 1'b0;
      #1;
      vectors++; if (bus.imem_addr !== 32'h100) begin miscompares++; $display("FAIL align_addr got %h exp 00000100", bus.imem_addr); end
      vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL align_req got %b exp 1", bus.imem_req); end
      cyc();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h200;
      #1;
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req0 got %b exp 0", bus.imem_req); end
      cyc();
      bus.redirect_pc = 32'h300;
      cyc();
      bus.redirect = 1'b0;
      #1;
      vectors++; if (bus.imem_addr !== 32'h300) begin miscompares++; $display("FAIL b2b_addr got %h exp 00000300", bus.imem_addr); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble0 got %b exp 0", bus.out_valid); end
      cyc();
      #1;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble1 got %b exp 0", bus.out_valid); end
      cyc();
      #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b exp 1", bus.out_valid); end
      vectors++; if (bus.out_pc !== 32'h300) begin miscompares++; $display("FAIL b2b_pc got %h exp 00000300", bus.out_pc); end
      cyc();
   endtask

   task automatic test_wrap();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      cyc();
      bus.redirect = 1'b0;
      #1;
      vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0 got %h exp fffffffc", bus.imem_addr); end
      cyc();
      #1;
      vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1 got %h exp 00000000", bus.imem_addr); end
      cyc();
      #1;
      vectors++; if (bus.out_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc got %h exp fffffffc", bus.out_pc); end
      vectors++; if (bus.out_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4 got %h exp 00000000", bus.out_pc_plus4); end
      vectors++; if (bus.out_instr !== mem_word(32'hFFFF_FFFC)) begin miscompares++; $display("FAIL wrap_instr got %h exp %h", bus.out_instr, mem_word(32'hFFFF_FFFC)); end
      cyc();
      #1;
      vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_next_pc got %h exp 00000000", bus.out_pc); end
      vectors++; if (bus.out_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL wrap_next_plus4 got %h exp 00000004", bus.out_pc_plus4); end
      cyc();
   endtask

   task automatic test_reset_midstall();
      start(1'b0);
      repeat (6) cyc();
      #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full_valid got %b exp 1", bus.out_valid); end
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_full_req got %b exp 0", bus.imem_req); end
      #1;
      rst = 1'b0;
      #1;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_rst_req got %b exp 0", bus.imem_req); end
      vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst_addr got %h exp 00000000", bus.imem_addr); end
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL restart_req got %b exp 1", bus.imem_req); end
      vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL restart_addr got %h exp 00000000", bus.imem_addr); end
      cyc();
      cyc();
      #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid got %b exp 1", bus.out_valid); end
      vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL restart_pc got %h exp 00000000", bus.out_pc); end
   endtask

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_midstall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
